capture_sink: RTL and testbench

Parametrised capture sink for the receive-side text path: after an `arm` pulse it discards a configurable number of leading valid samples (pipeline/latency alignment), then writes incoming words into an internal RAM at incrementing addresses until a programmable length is reached. It supports two modes: one-shot, and circular (wrap-around) capture ended by `stop`. A registered read port lets the host or bench read the captured buffer back. It replaces the fixed 8-bit, fixed-length sink.

---
 rtl/capture_sink.sv | 191 +++++++++++++++++++
 tb/tb_capture_sink.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sink.sv
// capture_sink
//   Receive-side capture buffer. An arm pulse restarts a capture: the first
//   SKIP valid samples are dropped for latency alignment. After that, samples
//   are written to an internal RAM at incrementing addresses. The capture
//   stops after capture_len words (one-shot), or keeps running and overwrites
//   the oldest words until stop (circular). A registered read port gives
//   access to the buffer in every state.
//
//   Optional feature macro: CAPTURE_CHECKSUM_EN. When it is defined, a 16-bit
//   running sum of the captured words drives checksum. When it is not
//   defined, checksum is tied to 0.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   data_in, valid_in           sample stream, no back-pressure
//   arm, stop                   start/restart pulse; end capture
//   wrap_mode, capture_len      mode and length, both sampled on arm
//   busy, done, wrapped         status
//   wr_addr, count              next write address; valid words in buffer
//   rd_addr, rd_data            read port, 1-cycle latency, 0 beyond DEPTH
//   checksum                    running sum of captured words
module capture_sink #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int SKIP   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              arm,
  input  logic              stop,
  input  logic              wrap_mode,
  input  logic [ADDR_W:0]   capture_len,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       checksum
);

  localparam int SKIP_W = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                wrapped_reg, wrapped_next;
  logic [SKIP_W-1:0]   skip_cnt_reg, skip_cnt_next;
  logic [ADDR_W:0]     len_reg, len_next;
  logic                wrap_mode_reg, wrap_mode_next;
  logic                we;
  logic                last_slot;

  logic [DATA_W-1:0]   mem [DEPTH];

  // The write that lands on address len-1 ends (or wraps) the buffer.
  assign last_slot = ({1'b0, wr_addr_reg} == (len_reg - (ADDR_W + 1)'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wr_addr_reg   <= '0;
      count_reg     <= '0;
      wrapped_reg   <= 1'b0;
      skip_cnt_reg  <= '0;
      len_reg       <= '0;
      wrap_mode_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_addr_reg   <= wr_addr_next;
      count_reg     <= count_next;
      wrapped_reg   <= wrapped_next;
      skip_cnt_reg  <= skip_cnt_next;
      len_reg       <= len_next;
      wrap_mode_reg <= wrap_mode_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_addr_next   = wr_addr_reg;
    count_next     = count_reg;
    wrapped_next   = wrapped_reg;
    skip_cnt_next  = skip_cnt_reg;
    len_next       = len_reg;
    wrap_mode_next = wrap_mode_reg;
    we             = 1'b0;

    if (arm) begin
      // Arm wins over stop and valid_in. A sample in this cycle is dropped.
      wrap_mode_next = wrap_mode;
      len_next       = (capture_len > DEPTH_L) ? DEPTH_L : capture_len;
      wr_addr_next   = '0;
      count_next     = '0;
      wrapped_next   = 1'b0;
      skip_cnt_next  = '0;
      if (len_next == '0)
        state_next = S_DONE;
      else if (SKIP == 0)
        state_next = S_CAPTURE;
      else
        state_next = S_SKIP;
    end else begin
      case (state_reg)
        S_SKIP: begin
          if (stop) begin
            state_next = S_DONE;
          end else if (valid_in) begin
            // The SKIPth sample is also discarded, then capture begins.
            if (int'(skip_cnt_reg) + 1 >= SKIP)
              state_next = S_CAPTURE;
            else
              skip_cnt_next = skip_cnt_reg + SKIP_W'(1);
          end
        end
        S_CAPTURE: begin
          if (valid_in) begin
            we         = 1'b1;
            count_next = (count_reg == len_reg) ? count_reg
                                                : count_reg + (ADDR_W + 1)'(1);
            if (last_slot && wrap_mode_reg) begin
              wr_addr_next = '0;
              wrapped_next = 1'b1;
            end else begin
              wr_addr_next = wr_addr_reg + ADDR_W'(1);
              if (last_slot)
                state_next = S_DONE;
            end
          end
          // A sample arriving together with stop is still written above.
          if (stop)
            state_next = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Buffer RAM: synchronous write, registered read. The read sees the old
  // data when it hits the address that is written in the same cycle.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr_reg] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < DEPTH_L)
      rd_data <= mem[rd_addr];
    else
      rd_data <= '0;
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] checksum_reg, checksum_next;

  always_comb begin
    checksum_next = checksum_reg;
    if (arm)
      checksum_next = '0;
    else if (we)
      checksum_next = checksum_reg + 16'(data_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      checksum_reg <= '0;
    else
      checksum_reg <= checksum_next;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign busy    = (state_reg == S_SKIP) || (state_reg == S_CAPTURE);
  assign done    = (state_reg == S_DONE);
  assign wrapped = wrapped_reg;
  assign wr_addr = wr_addr_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_capture_sink.sv
// tb_capture_sink
//   Self-checking bench for capture_sink (DATA_W=8, ADDR_W=8, DEPTH=256,
//   SKIP=2). The reference model describes a capture in terms of how many
//   valid samples arrived since arm (nval) and how many were captured (k).
//   From those two numbers it derives count, wr_addr, wrapped and checksum.
//   It also keeps an array image of the RAM for read-back.
module tb_capture_sink;

  localparam int SKIP  = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, arm, stop, valid_in, wrap_mode;
  logic [7:0]  data_in, rd_addr;
  logic [8:0]  capture_len;
  logic        busy, done, wrapped;
  logic [7:0]  wr_addr, rd_data;
  logic [8:0]  count;
  logic [15:0] checksum;

  capture_sink #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .SKIP(SKIP)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .arm(arm), .stop(stop), .wrap_mode(wrap_mode), .capture_len(capture_len),
    .busy(busy), .done(done), .wrapped(wrapped), .wr_addr(wr_addr),
    .count(count), .rd_addr(rd_addr), .rd_data(rd_data), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         armed, ended, m_wrap;
  int         m_len, nval, k, sum;
  logic [7:0] ref_mem [DEPTH];
  bit         ref_valid [DEPTH];
  logic [7:0] exp_rd;
  bit         rd_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
    return (k < m_len) ? k : m_len;
  endfunction

  function automatic int exp_wr();
    if (m_len == 0) return 0;
    return m_wrap ? (k % m_len) : (k % 256);
  endfunction

  function automatic int exp_sum();
`ifdef CAPTURE_CHECKSUM_EN
    return sum & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  // Apply the rules for the edge that just happened, using the inputs that
  // were present at that edge.
  task automatic model_edge();
    int wa;
    rd_known = ref_valid[rd_addr];
    exp_rd   = ref_mem[rd_addr];
    if (arm) begin
      m_wrap = wrap_mode;
      m_len  = (int'(capture_len) > DEPTH) ? DEPTH : int'(capture_len);
      nval = 0; k = 0; sum = 0;
      armed = 1; ended = (m_len == 0);
    end else if (armed && !ended) begin
      if (nval < SKIP) begin
        if (stop) ended = 1;
        else if (valid_in) nval++;
      end else begin
        if (valid_in) begin
          wa = m_wrap ? (k % m_len) : k;
          ref_mem[wa] = data_in;
          ref_valid[wa] = 1;
          k++;
          sum += int'(data_in);
          if (!m_wrap && k == m_len) ended = 1;
        end
        if (stop) ended = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("busy",     busy,     (armed && !ended) ? 1 : 0);
    check("done",     done,     (armed && ended) ? 1 : 0);
    check("wrapped",  wrapped,  (m_wrap && m_len > 0 && k >= m_len) ? 1 : 0);
    check("wr_addr",  wr_addr,  exp_wr());
    check("count",    count,    exp_count());
    check("checksum", checksum, exp_sum());
    if (rd_known) check("rd_data", rd_data, exp_rd);
  endtask

  task automatic cyc(input bit a, input bit s, input bit v, input logic [7:0] d,
                     input bit w, input logic [8:0] l, input logic [7:0] ra);
    arm = a; stop = s; valid_in = v; data_in = d;
    wrap_mode = w; capture_len = l; rd_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_count", count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rd_data", rd_data, 0);
    armed = 0; ended = 0; m_wrap = 0; m_len = 0; nval = 0; k = 0; sum = 0;
    rd_known = 1; exp_rd = 8'h00;
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] circ_exp [4];
    bit ra_, st_, vl_, wm_;
    logic [8:0] ln_;

    reset = 1'b1; arm = 0; stop = 0; valid_in = 0; wrap_mode = 0;
    data_in = 0; rd_addr = 0; capture_len = 0;
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 0;
    #2;
    do_reset();

    // One-shot, continuous valid.
    cyc(1, 0, 0, 8'h00, 0, 9'd10, 8'd0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'(i), 0, 9'd0, 8'd0);
    cyc(0, 0, 0, 8'h00, 0, 9'd0, 8'd0);
    check("t1_done", done, 1);
    check("t1_count", count, 10);
`ifdef CAPTURE_CHECKSUM_EN
    check("t1_checksum", checksum, 16'h0041);
`else
    check("t1_checksum", checksum, 16'h0000);
`endif
    for (int a = 0; a < 10; a++) begin
      cyc(0, 0, 0, 8'h00, 0, 9'd0, 8'(a));
      check("t1_readback", rd_data, 8'(a + 2));
    end

    // One-shot, valid every other cycle.
    cyc(1, 0, 0, 8'h00, 0, 9'd10, 8'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 8'(i), 0, 9'd0, 8'd0);
      cyc(0, 0, 0, 8'hAA, 0, 9'd0, 8'd0);
    end
    check("t2_count", count, 10);
    check("t2_done", done, 1);

    // Circular, 4 words, stop together with the last sample.
    cyc(1, 0, 0, 8'h00, 1, 9'd4, 8'd0);
    cyc(0, 0, 1, 8'hEE, 0, 9'd0, 8'd0);
    cyc(0, 0, 1, 8'hEF, 0, 9'd0, 8'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'(8'h10 + i), 0, 9'd0, 8'd0);
    cyc(0, 1, 1, 8'h16, 0, 9'd0, 8'd0);
    check("t3_wr_addr", wr_addr, 3);
    check("t3_wrapped", wrapped, 1);
    check("t3_count", count, 4);
    check("t3_done", done, 1);
    circ_exp[0] = 8'h14; circ_exp[1] = 8'h15; circ_exp[2] = 8'h16; circ_exp[3] = 8'h13;
    for (int a = 0; a < 4; a++) begin
      cyc(0, 0, 0, 8'h00, 0, 9'd0, 8'(a));
      check("t3_readback", rd_data, circ_exp[a]);
    end

    // Zero length: done right after the arm edge.
    cyc(1, 0, 1, 8'h55, 0, 9'd0, 8'd0);
    check("t4_done", done, 1);
    check("t4_count", count, 0);

    // Oversized length clamps to DEPTH.
    cyc(1, 0, 0, 8'h00, 0, 9'(DEPTH + 5), 8'd0);
    for (int i = 0; i < DEPTH + 8; i++) cyc(0, 0, 1, 8'($urandom), 0, 9'd0, 8'($urandom));
    check("t5_count", count, DEPTH);
    check("t5_done", done, 1);

    // Re-arm with valid mid-capture.
    cyc(1, 0, 0, 8'h00, 0, 9'd8, 8'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h30 + i), 0, 9'd0, 8'd0);
    cyc(1, 1, 1, 8'h99, 0, 9'd8, 8'd0);
    check("t6_count", count, 0);
    check("t6_wr_addr", wr_addr, 0);
    check("t6_busy", busy, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0, 9'd0, 8'd0);

    // Asynchronous reset mid-capture.
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      ra_ = ($urandom_range(0, 24) == 0);
      st_ = ($urandom_range(0, 40) == 0);
      vl_ = ($urandom_range(0, 9) < 7);
      wm_ = $urandom_range(0, 1);
      ln_ = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                        : 9'($urandom_range(0, 12));
      cyc(ra_, st_, vl_, 8'($urandom), wm_, ln_, 8'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
